// File: rtl/recepcao_serial.sv
// rtl/recepcao_serial.sv - 8N1 serial receiver that assembles 16-bit pixels and writes a LINESxCOLUMNS RAM frame
module recepcao_serial #(
   parameter int M_BAUD   = 434,
   parameter int LINES    = 3,
   parameter int COLUMNS  = 3,
   parameter int S_DATA   = 16,
   parameter int S_LINE   = 2,
   parameter int S_COLUMN = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                partida,
   input  logic                entrada_serial,
   output logic                we,
   output logic [S_DATA-1:0]   data,
   output logic [S_LINE-1:0]   addr_line,
   output logic [S_COLUMN-1:0] addr_column,
   output logic                pronto,
   output logic                erro,
   output logic [7:0]          db_byte,
   output logic [3:0]          db_estado
);

   localparam int CW = $clog2(M_BAUD);
   localparam logic [CW-1:0] HALF_BIT = CW'(M_BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL_BIT = CW'(M_BAUD - 1);
   localparam logic [S_LINE-1:0]   LAST_LINE   = S_LINE'(LINES - 1);
   localparam logic [S_COLUMN-1:0] LAST_COLUMN = S_COLUMN'(COLUMNS - 1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DADOS = 2'd2,
      RX_STOP  = 2'd3
   } rx_estado_t;

   typedef enum logic [2:0] {
      OCIOSO       = 3'd0,
      ESPERA_ALTO  = 3'd1,
      ESPERA_BAIXO = 3'd2,
      ESCREVE      = 3'd3,
      PROXIMO      = 3'd4,
      FIM          = 3'd5
   } estado_t;

   logic          sync_a;
   logic          sync_b;
   logic          sync_prev;
   rx_estado_t    rx_estado;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic [7:0]    rx_data;
   logic          byte_ok;
   logic          byte_err;
   estado_t       estado;

   // Synchroniser plus one extra stage so a falling edge can be seen on clean samples.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_a    <= 1'b1;
         sync_b    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_a    <= entrada_serial;
         sync_b    <= sync_a;
         sync_prev <= sync_b;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_estado <= RX_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         byte_ok   <= 1'b0;
         byte_err  <= 1'b0;
      end else begin
         byte_ok  <= 1'b0;
         byte_err <= 1'b0;
         case (rx_estado)
            RX_IDLE: begin
               if (sync_prev && !sync_b) begin
                  baud_cnt  <= HALF_BIT;
                  rx_estado <= RX_START;
               end
            end
            RX_START: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - 1'b1;
               end else if (sync_b) begin
                  rx_estado <= RX_IDLE;
               end else begin
                  baud_cnt  <= FULL_BIT;
                  bit_cnt   <= '0;
                  rx_estado <= RX_DADOS;
               end
            end
            RX_DADOS: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - 1'b1;
               end else begin
                  shift    <= {sync_b, shift[7:1]};
                  baud_cnt <= FULL_BIT;
                  if (bit_cnt == 3'd7) begin
                     rx_estado <= RX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (baud_cnt != '0) begin
                  baud_cnt <= baud_cnt - 1'b1;
               end else begin
                  if (sync_b) begin
                     byte_ok <= 1'b1;
                     rx_data <= shift;
                  end else begin
                     byte_err <= 1'b1;
                  end
                  rx_estado <= RX_IDLE;
               end
            end
            default: rx_estado <= RX_IDLE;
         endcase
      end
   end

   // Frame sequencer: high byte first, then low byte, one write per pixel in row-major order.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado      <= OCIOSO;
         we          <= 1'b0;
         data        <= '0;
         addr_line   <= '0;
         addr_column <= '0;
         pronto      <= 1'b0;
         erro        <= 1'b0;
      end else begin
         we <= 1'b0;
         case (estado)
            OCIOSO, FIM: begin
               if (partida) begin
                  addr_line   <= '0;
                  addr_column <= '0;
                  erro        <= 1'b0;
                  pronto      <= 1'b0;
                  estado      <= ESPERA_ALTO;
               end
            end
            ESPERA_ALTO: begin
               if (byte_ok) begin
                  data[15:8] <= rx_data;
                  estado     <= ESPERA_BAIXO;
               end else if (byte_err) begin
                  erro <= 1'b1;
               end
            end
            ESPERA_BAIXO: begin
               if (byte_ok) begin
                  data[7:0] <= rx_data;
                  estado    <= ESCREVE;
               end else if (byte_err) begin
                  erro   <= 1'b1;
                  estado <= ESPERA_ALTO;
               end
            end
            ESCREVE: begin
               we     <= 1'b1;
               estado <= PROXIMO;
            end
            PROXIMO: begin
               // The write pulse is live this cycle; addresses move only at its end.
               if (addr_column == LAST_COLUMN && addr_line == LAST_LINE) begin
                  pronto <= 1'b1;
                  estado <= FIM;
               end else if (addr_column == LAST_COLUMN) begin
                  addr_column <= '0;
                  addr_line   <= addr_line + 1'b1;
                  estado      <= ESPERA_ALTO;
               end else begin
                  addr_column <= addr_column + 1'b1;
                  estado      <= ESPERA_ALTO;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign db_byte   = rx_data;
   assign db_estado = {1'b0, estado};

endmodule

// File: doc/recepcao_serial.md
Name: recepcao_serial

Overview:
- Receive-side counterpart of the serial transmission datapath. Takes an 8N1 serial stream, pairs bytes into 16-bit pixels and writes them into the 3x3 pixel RAM write port.
- Pixels are written in row-major order. A start pulse arms the block for one frame; completion is signalled to the control unit.
- Contains its own UART receiver with baud timing, a byte-pairing register, line/column address counters and a frame state machine.

Parameters:
- M_BAUD, 434, clock cycles per serial bit (115200 baud at 50 MHz); minimum 4.
- LINES, 3, number of RAM lines per frame.
- COLUMNS, 3, number of RAM columns per frame.
- S_DATA, 16, pixel width; fixed at 2 bytes.
- S_LINE, 2, line address width.
- S_COLUMN, 2, column address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- partida  in  1  one-cycle pulse that arms reception of one frame
- entrada_serial  in  1  asynchronous serial line; idle high
- we  out  1  RAM write enable, one-cycle pulse
- data  out  S_DATA  pixel to write; valid when we=1
- addr_line  out  S_LINE  RAM line address; valid when we=1
- addr_column  out  S_COLUMN  RAM column address; valid when we=1
- pronto  out  1  frame complete; level signal
- erro  out  1  sticky framing-error flag for the current frame
- db_byte  out  8  last byte received with a valid stop bit
- db_estado  out  4  frame FSM state code (debug)

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high, and takes effect at the next rising clock edge.
  - Reset values: we=0, data=0, addr_line=0, addr_column=0, pronto=0, erro=0, db_byte=0, db_estado=0 (ocioso).
  - Reset mid-byte or mid-frame aborts everything and returns to these values. Partial pixel data is discarded.
- Input synchroniser: entrada_serial passes through a 2-flop synchroniser, reset to 1. All timing below is relative to the synchronised signal.
- UART RX FSM (states: rx_idle, rx_start, rx_dados, rx_stop):
  - rx_idle: on a synchronised 1->0 edge, load the baud counter and go to rx_start.
  - rx_start: wait M_BAUD/2 cycles, then sample.
    - Line is 1: glitch; return to rx_idle.
    - Line is 0: go to rx_dados.
  - rx_dados: sample 8 bits every M_BAUD cycles, LSB first, into a shift register.
  - rx_stop: sample once after M_BAUD cycles.
    - Stop bit = 1: raise the internal byte_ok pulse for one cycle and update db_byte.
    - Stop bit = 0: raise the internal byte_err pulse for one cycle; db_byte is unchanged.
    - Either way, return to rx_idle.
  - The receiver runs continuously, independent of the frame FSM.
- Frame FSM (states: ocioso=0, espera_alto=1, espera_baixo=2, escreve=3, proximo=4, fim=5):
  - ocioso:
    - On partida: clear both address counters to 0, clear erro and pronto, go to espera_alto.
    - Bytes received in ocioso are ignored.
  - espera_alto:
    - byte_ok: latch the byte into data[15:8], go to espera_baixo.
  - espera_baixo:
    - byte_ok: latch the byte into data[7:0], go to escreve.
    - byte_err: set erro=1, return to espera_alto (the pixel restarts at its high byte).
  - byte_err in espera_alto: set erro=1 and stay in espera_alto.
  - escreve:
    - we=1 for exactly this one cycle, with data, addr_line and addr_column stable.
    - we rises 2 cycles after the byte_ok of the low byte.
  - proximo:
    - If addr_column = COLUMNS-1 and addr_line = LINES-1: go to fim.
    - Else if addr_column = COLUMNS-1: set addr_column=0, increment addr_line, go to espera_alto.
    - Else: increment addr_column, go to espera_alto.
  - fim:
    - pronto=1. Addresses hold at their last value.
    - partida restarts exactly as from ocioso, and clears pronto that same edge.
- partida outside ocioso/fim is ignored.
- Byte order: the high byte (bits 15:8) is received first, matching the transmitter's shift order.
- Pixel order: (0,0),(0,1),(0,2),(1,0),…,(2,2), i.e. 9 writes per frame at the defaults.
- erro does not stop the frame. The affected pixel is re-received from its high byte, and the pixel count is not advanced.
- Counters never exceed LINES-1 / COLUMNS-1. No wrap occurs within a frame.

Test Plan (M_BAUD=4 in simulation):
- Reset, then idle line high -> all outputs 0, db_estado=0. Send byte 0xA5 with no partida -> db_byte=0xA5, we never asserted.
- partida, then 18 bytes 0x00,0x01,0x00,0x02,…,0x00,0x09 -> 9 we pulses with data 0x0001…0x0009 at (0,0)…(2,2) in row-major order. pronto=1 one cycle after the last proximo; erro=0.
- Within a frame, send a start bit that returns to 1 after 1 cycle -> no byte_ok, no we, state unchanged.
- High byte 0x12, then low byte 0x34 with stop=0, then 0x56, 0x78 -> erro=1; the single write for this pixel carries data=0x5678 at the current address.
- Assert reset mid-low-byte during pixel (1,1) -> outputs return to reset values. A new partida plus 18 bytes writes a full frame from (0,0).
- In fim, pulse partida -> pronto falls on the same edge and the addresses restart at (0,0); a second full frame completes correctly.
